// File: rtl/clint_multi.sv
// Multi-hart core-local interruptor: shared 64-bit mtime with tick prescaler,
// per-hart msip/mtimecmp, registered read path and interrupt outputs.
module clint_multi #(
  parameter int NUM_HARTS = 2,
  parameter int TICK_DIV  = 1
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 req_in,
  input  logic                 we_in,
  input  logic [31:0]          addr_in,
  input  logic [31:0]          data_in,
  output logic [31:0]          data_out,
  output logic                 ack_out,
  output logic [NUM_HARTS-1:0] timer_interrupt_req_out,
  output logic [NUM_HARTS-1:0] software_interrupt_req_out
);

  localparam logic [15:0] DIV_LAST = 16'(TICK_DIV - 1);

  logic [15:0]          pre_cnt;
  logic                 tick;
  logic [63:0]          mtime;
  logic [63:0]          mtimecmp [NUM_HARTS];
  logic [NUM_HARTS-1:0] msip;

  logic [15:0]          a;
  logic                 wr;
  logic                 rd;
  logic                 sel_mtime_lo;
  logic                 sel_mtime_hi;
  logic [NUM_HARTS-1:0] hit_msip;
  logic [NUM_HARTS-1:0] hit_cmp_lo;
  logic [NUM_HARTS-1:0] hit_cmp_hi;
  logic [31:0]          rdata;

  assign a    = addr_in[15:0];
  assign wr   = req_in & we_in;
  assign rd   = req_in & ~we_in;
  assign tick = (pre_cnt == DIV_LAST);

  assign sel_mtime_lo = (a == 16'hBFF8);
  assign sel_mtime_hi = (a == 16'hBFFC);

  // Per-hart decode keeps out-of-range harts from ever indexing the arrays
  always_comb begin
    hit_msip   = '0;
    hit_cmp_lo = '0;
    hit_cmp_hi = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      hit_msip[h] = (a[15:14] == 2'b00) &&
                    (a[1:0] == 2'b00) &&
                    (a[13:2] == 12'(h));
      hit_cmp_lo[h] = (a[15:14] == 2'b01) &&
                      (a[2:0] == 3'b000) &&
                      (a[13:3] == 11'(h));
      hit_cmp_hi[h] = (a[15:14] == 2'b01) &&
                      (a[2:0] == 3'b100) &&
                      (a[13:3] == 11'(h));
    end
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_mtime_lo: rdata = mtime[31:0];
      sel_mtime_hi: rdata = mtime[63:32];
      default: begin
        for (int h = 0; h < NUM_HARTS; h++) begin
          if (hit_msip[h])
            rdata = {31'b0, msip[h]};
          if (hit_cmp_lo[h])
            rdata = mtimecmp[h][31:0];
          if (hit_cmp_hi[h])
            rdata = mtimecmp[h][63:32];
        end
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      pre_cnt  <= '0;
      mtime    <= '0;
      msip     <= '0;
      data_out <= '0;
      ack_out  <= 1'b0;
      timer_interrupt_req_out    <= '0;
      software_interrupt_req_out <= '0;
      for (int h = 0; h < NUM_HARTS; h++)
        mtimecmp[h] <= '1;
    end else begin
      ack_out <= req_in;
      if (rd)
        data_out <= rdata;

      pre_cnt <= tick ? '0 : pre_cnt + 16'd1;

      // A software write to either half suppresses that cycle's increment
      if (wr && sel_mtime_lo)
        mtime[31:0] <= data_in;
      else if (wr && sel_mtime_hi)
        mtime[63:32] <= data_in;
      else if (tick)
        mtime <= mtime + 64'd1;

      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr && hit_msip[h])
          msip[h] <= data_in[0];
        if (wr && hit_cmp_lo[h])
          mtimecmp[h][31:0] <= data_in;
        if (wr && hit_cmp_hi[h])
          mtimecmp[h][63:32] <= data_in;
        timer_interrupt_req_out[h] <= (mtime >= mtimecmp[h]);
        software_interrupt_req_out[h] <= msip[h];
      end
    end
  end

endmodule

// File: tb/tb_clint_multi.sv
// Directed bench for clint_multi: TICK_DIV=4 main instance plus a
// TICK_DIV=1 instance for the free-running mtime check.
module tb_clint_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req, we;
  logic [31:0] addr, wdata;
  logic [31:0] dout;
  logic        ack;
  logic [1:0]  tirq, sirq;

  logic        req1;
  logic [31:0] addr1;
  logic [31:0] dout1;
  logic        ack1;
  logic [1:0]  tirq1, sirq1;

  clint_multi #(.NUM_HARTS(2), .TICK_DIV(4)) dut (
    .clk_in(clk),
    .reset_in(rst),
    .req_in(req),
    .we_in(we),
    .addr_in(addr),
    .data_in(wdata),
    .data_out(dout),
    .ack_out(ack),
    .timer_interrupt_req_out(tirq),
    .software_interrupt_req_out(sirq)
  );

  clint_multi #(.NUM_HARTS(2), .TICK_DIV(1)) dut1 (
    .clk_in(clk),
    .reset_in(rst),
    .req_in(req1),
    .we_in(1'b0),
    .addr_in(addr1),
    .data_in(32'h0),
    .data_out(dout1),
    .ack_out(ack1),
    .timer_interrupt_req_out(tirq1),
    .software_interrupt_req_out(sirq1)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] sb[$];

  // cycles since the reset edge; prescaler phase of the TICK_DIV=4 instance
  int k;
  always @(posedge clk)
    if (rst) k <= 0;
    else k <= k + 1;

  function automatic int ticks(input int from, input int upto);
    int n = 0;
    for (int j = from; j < upto; j++)
      if (j % 4 == 3) n++;
    return n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [15:0] a, input logic [31:0] e,
                    input string tag);
    req = 1'b1;
    we = 1'b0;
    addr = {16'hA5A5, a};
    sb.push_back(e);
    step();
    req = 1'b0;
    chk({tag, "_ack"}, ack, 1);
    chk(tag, dout, sb.pop_front());
  endtask

  task automatic wr(input logic [15:0] a, input logic [31:0] d,
                    input string tag);
    req = 1'b1;
    we = 1'b1;
    addr = {16'h5A5A, a};
    wdata = d;
    step();
    req = 1'b0;
    we = 1'b0;
    chk({tag, "_ack"}, ack, 1);
  endtask

  initial begin
    int c0;
    logic [31:0] tgt;
    logic [31:0] e;
    logic seen;

    rst = 1'b1;
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    req1 = 1'b0; addr1 = '0;
    step();
    rst = 1'b0;
    chk("rst_ack", ack, 0);
    chk("rst_dout", dout, 0);
    chk("rst_tirq", tirq, 0);
    chk("rst_sirq", sirq, 0);

    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_irq1", {tirq1, sirq1}, 0);
    end
    req1 = 1'b1;
    addr1 = 32'h0000_BFF8;
    chk("d1_noack_yet", ack1, 0);
    step();
    req1 = 1'b0;
    chk("d1_ack", ack1, 1);
    chk("d1_mtime_range", (dout1 >= 9 && dout1 <= 11), 1);

    rd(16'h4000, 32'hFFFF_FFFF, "cmp0_lo_rst");
    rd(16'h400C, 32'hFFFF_FFFF, "cmp1_hi_rst");
    rd(16'h0000, 32'h0, "msip0_rst");
    chk("rst_irq_idle", {tirq, sirq}, 0);

    wr(16'hBFF8, 32'hFFFF_FFFE, "carry_wlo");
    wr(16'hBFFC, 32'h0, "carry_whi");
    for (int i = 0; i < 8; i++) step();
    rd(16'hBFF8, 32'h0, "carry_lo");
    rd(16'hBFFC, 32'h1, "carry_hi");

    for (int i = 0; i < 4 && (k % 4) != 1; i++) step();
    wr(16'hBFF8, 32'h10, "tw_lo");
    wr(16'hBFFC, 32'h2, "tw_hi");
    wr(16'hBFF8, 32'h5, "tw_tick");
    rd(16'hBFF8, 32'h5, "tw_rd_lo");
    rd(16'hBFFC, 32'h2, "tw_rd_hi");

    wr(16'hBFF8, 32'h0, "tm_zlo");
    wr(16'hBFFC, 32'h0, "tm_zhi");
    c0 = k;
    tgt = 32'(ticks(c0, k)) + 32'd20;
    wr(16'h400C, 32'h0, "tm_cmphi");
    wr(16'h4008, tgt, "tm_cmplo");
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      e = 32'(ticks(c0, k));
      req = 1'b1;
      we = 1'b0;
      addr = 32'h0000_BFF8;
      sb.push_back(e);
      step();
      req = 1'b0;
      chk("tm_mtime", dout, sb.pop_front());
      chk("tm_bit1", tirq[1], (e >= tgt));
      chk("tm_bit0", tirq[0], 0);
      if (tirq[1]) seen = 1'b1;
      if (e > tgt) break;
    end
    chk("tm_rise_seen", seen, 1);
    wr(16'h4008, 32'hFFFF_FFFF, "tm_clr_lo");
    chk("tm_still_set", tirq[1], 1);
    wr(16'h400C, 32'hFFFF_FFFF, "tm_clr_hi");
    chk("tm_cleared", tirq[1], 0);

    wr(16'h0004, 32'h1, "sw_set");
    chk("sw_not_yet", sirq, 2'b00);
    step();
    chk("sw_set_vec", sirq, 2'b10);
    rd(16'h0004, 32'h1, "sw_rd1");
    wr(16'h0004, 32'hFFFF_FFFE, "sw_clr");
    chk("sw_clr_lag", sirq[1], 1);
    step();
    chk("sw_clr_vec", sirq, 2'b00);
    rd(16'h0004, 32'h0, "sw_rd0");

    rd(16'h0008, 32'h0, "bad_msip2");
    rd(16'h1234, 32'h0, "bad_1234");
    rd(16'h4010, 32'h0, "bad_cmp2");
    wr(16'h0008, 32'h1, "bad_wr");
    step();
    chk("bad_wr_noeff", sirq, 2'b00);

    wr(16'hBFF8, 32'hFFFF_FFFF, "wrap_lo");
    wr(16'hBFFC, 32'hFFFF_FFFF, "wrap_hi");
    for (int i = 0; i < 4; i++) step();
    rd(16'hBFF8, 32'h0, "wrap_rd_lo");
    rd(16'hBFFC, 32'h0, "wrap_rd_hi");

    wr(16'h0004, 32'h1, "mid_sw");
    wr(16'h4004, 32'h0, "mid_c0hi");
    wr(16'h4000, 32'h0, "mid_c0lo");
    step();
    chk("cmp_zero_pend", tirq, 2'b01);
    chk("mid_sw_on", sirq, 2'b10);
    req = 1'b1;
    we = 1'b0;
    addr = 32'h0000_BFF8;
    step();
    req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_ack_drop", ack, 0);
    chk("mid_dout", dout, 0);
    chk("mid_tirq", tirq, 0);
    chk("mid_sirq", sirq, 0);
    rd(16'h4000, 32'hFFFF_FFFF, "mid_cmp0");
    rd(16'h0004, 32'h0, "mid_msip1");
    step();
    chk("ack_idle", ack, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
